// File: rtl/fetch_unit_pkg.sv
// ============================================================================
// fetch_unit_pkg : shared widths, branch/condition encodings, FSM states
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_B    = 3'd1,
    BR_CBZ  = 3'd2,
    BR_CBNZ = 3'd3,
    BR_COND = 3'd4,
    BR_REG  = 3'd5,
    BR_BL   = 3'd6
  } branch_op_e;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_HS = 4'd2;
  localparam logic [3:0] COND_LO = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_HOLD   = 3'd2,
    ST_HALTED = 3'd3,
    ST_FAULT  = 3'd4
  } fetch_state_e;

  // nzcv is packed {N,Z,C,V}; NV behaves as always.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, pass;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_HS: pass = c;
      COND_LO: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !(c && !z);
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = !(!z && (n == v));
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_unit_if.sv
// ============================================================================
// fetch_unit_if : instruction-memory request/response handshake
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic                 req;
  logic [WORD-1:0]      addr;
  logic                 rvalid;
  logic [INSTR_LEN-1:0] rdata;

  modport master (output req, output addr, input rvalid, input rdata);
  modport slave  (input req, input addr, output rvalid, output rdata);

endinterface

`default_nettype wire

// File: rtl/fetch_unit_branch_resolve.sv
// ============================================================================
// fetch_unit_branch_resolve : combinational next-PC selection for one retire
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit_branch_resolve
  import fetch_unit_pkg::*;
(
  input  logic [2:0]      branch_op,
  input  logic [3:0]      flags,
  input  logic [3:0]      cond,
  input  logic            alu_zero,
  input  logic [WORD-1:0] pc,
  input  logic [WORD-1:0] offset,
  input  logic [WORD-1:0] target,
  output logic [WORD-1:0] next_pc,
  output logic            taken
);

  logic [WORD-1:0] seq_pc;
  logic [WORD-1:0] rel_pc;

  always_comb begin
    seq_pc  = pc + 64'd4;
    rel_pc  = pc + (offset << 2);
    taken   = 1'b0;
    next_pc = seq_pc;
    case (branch_op)
      BR_B, BR_BL: begin
        taken   = 1'b1;
        next_pc = rel_pc;
      end
      BR_CBZ: begin
        taken   = alu_zero;
        next_pc = alu_zero ? rel_pc : seq_pc;
      end
      BR_CBNZ: begin
        taken   = !alu_zero;
        next_pc = alu_zero ? seq_pc : rel_pc;
      end
      BR_COND: begin
        taken   = cond_pass(cond, flags);
        next_pc = taken ? rel_pc : seq_pc;
      end
      BR_REG: begin
        taken   = 1'b1;
        next_pc = target;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : PC register, imem fetch FSM with timeout, instruction hold
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC = 64'h0,
  parameter int              TIMEOUT  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  fetch_unit_if.master         imem,
  output logic [INSTR_LEN-1:0] instruction,
  output logic                 instr_valid,
  output logic [WORD-1:0]      pc,
  output logic [WORD-1:0]      pc_plus4,
  input  logic                 retire,
  input  logic [2:0]           branch_op,
  input  logic [WORD-1:0]      branch_offset,
  input  logic [WORD-1:0]      br_target,
  input  logic                 alu_zero,
  input  logic [3:0]           flags,
  input  logic [3:0]           cond,
  input  logic                 halt,
  output logic                 fault
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e         state_q, state_d;
  logic [WORD-1:0]      pc_q, pc_d;
  logic [INSTR_LEN-1:0] instr_q, instr_d;
  logic                 fault_q, fault_d;
  logic [CNT_W-1:0]     wait_q, wait_d;

  logic [WORD-1:0]      next_pc;
  logic                 taken;
  logic                 misaligned;

  fetch_unit_branch_resolve u_branch_resolve (
    .branch_op (branch_op),
    .flags     (flags),
    .cond      (cond),
    .alu_zero  (alu_zero),
    .pc        (pc_q),
    .offset    (branch_offset),
    .target    (br_target),
    .next_pc   (next_pc),
    .taken     (taken)
  );

  // A fall-through target keeps the low bits of pc, so only a taken branch can misalign.
  assign misaligned = (taken ? next_pc[1:0] : pc_q[1:0]) != 2'b00;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    fault_d = fault_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        wait_d  = '0;
      end
      ST_FETCH: begin
        if (imem.rvalid) begin
          instr_d = imem.rdata;
          state_d = ST_HOLD;
        end else if (wait_q == CNT_W'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = ST_FAULT;
        end else begin
          wait_d = wait_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (retire) begin
          if (misaligned) begin
            fault_d = 1'b1;
            state_d = ST_FAULT;
          end else begin
            pc_d    = next_pc;
            wait_d  = '0;
            state_d = halt ? ST_HALTED : ST_FETCH;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      fault_q <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      wait_q  <= wait_d;
    end
  end

  // Request follows the registered state so an asynchronous reset drops it at once.
  assign imem.req    = (state_q == ST_FETCH);
  assign imem.addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = (state_q == ST_HOLD);
  assign pc          = pc_q;
  assign pc_plus4    = pc_q + 64'd4;
  assign fault       = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// tb_fetch_unit : directed stimulus, behavioural model and per-cycle compare
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          TIMEOUT  = 16;

  localparam int PH_IDLE  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_HOLD  = 2;
  localparam int PH_STOP  = 3;
  localparam int PH_FAULT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        retire = 1'b0;
  logic        halt = 1'b0;
  logic [2:0]  branch_op = 3'd0;
  logic [63:0] branch_offset = 64'd0;
  logic [63:0] br_target = 64'd0;
  logic        alu_zero = 1'b0;
  logic [3:0]  flags = 4'd0;
  logic [3:0]  cond = 4'd0;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [63:0] pc;
  logic [63:0] pc_plus4;
  logic        fault;

  int checks = 0;
  int errors = 0;
  int mem_lat = 0;
  logic force_rv = 1'b0;
  logic cmp_en = 1'b0;

  fetch_unit_if imem_if ();

  fetch_unit #(.RESET_PC(RESET_PC), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .reset         (reset),
    .imem          (imem_if),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .retire        (retire),
    .branch_op     (branch_op),
    .branch_offset (branch_offset),
    .br_target     (br_target),
    .alu_zero      (alu_zero),
    .flags         (flags),
    .cond          (cond),
    .halt          (halt),
    .fault         (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'hE000_0000 | {4'h0, a[27:0]};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_ph;
  int          m_wait;
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic        m_fault;

  function automatic logic m_cond_ok(input logic [3:0] cd, input logic [3:0] fl);
    logic n, z, c, v;
    {n, z, c, v} = fl;
    case (cd)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c & !z;
      4'd9:  return !c | z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z & (n == v);
      4'd13: return z | (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [63:0] m_next(input logic [2:0] op, input logic [63:0] p,
                                         input logic [63:0] off, input logic [63:0] tgt,
                                         input logic z, input logic [3:0] fl, input logic [3:0] cd);
    logic [63:0] br;
    br = p + off * 64'd4;
    case (op)
      3'd1, 3'd6: return br;
      3'd2:       return z ? br : p + 64'd4;
      3'd3:       return z ? p + 64'd4 : br;
      3'd4:       return m_cond_ok(cd, fl) ? br : p + 64'd4;
      3'd5:       return tgt;
      default:    return p + 64'd4;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph    <= PH_IDLE;
      m_wait  <= 0;
      m_pc    <= RESET_PC;
      m_instr <= 32'd0;
      m_fault <= 1'b0;
    end else begin
      if (m_ph == PH_IDLE) begin
        m_ph   <= PH_FETCH;
        m_wait <= 0;
      end else if (m_ph == PH_FETCH) begin
        if (imem_if.rvalid) begin
          m_instr <= imem_if.rdata;
          m_ph    <= PH_HOLD;
        end else if (m_wait + 1 >= TIMEOUT) begin
          m_fault <= 1'b1;
          m_ph    <= PH_FAULT;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (m_ph == PH_HOLD && retire) begin
        if (m_next(branch_op, m_pc, branch_offset, br_target, alu_zero, flags, cond) % 4 != 0) begin
          m_fault <= 1'b1;
          m_ph    <= PH_FAULT;
        end else begin
          m_pc   <= m_next(branch_op, m_pc, branch_offset, br_target, alu_zero, flags, cond);
          m_wait <= 0;
          m_ph   <= halt ? PH_STOP : PH_FETCH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_req", {63'd0, imem_if.req}, {63'd0, m_ph == PH_FETCH});
      chk("imem_addr", imem_if.addr, m_pc);
      chk("instr_valid", {63'd0, instr_valid}, {63'd0, m_ph == PH_HOLD});
      chk("instruction", {32'd0, instruction}, {32'd0, m_instr});
      chk("pc", pc, m_pc);
      chk("pc_plus4", pc_plus4, m_pc + 64'd4);
      chk("fault", {63'd0, fault}, {63'd0, m_fault});
    end
  end

  // ---------------- instruction memory responder ----------------
  initial begin
    int wcnt;
    wcnt = 0;
    imem_if.rvalid = 1'b0;
    imem_if.rdata  = 32'd0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && imem_if.req && !force_rv) begin
        if (wcnt >= mem_lat) begin
          imem_if.rvalid = 1'b1;
          imem_if.rdata  = mem_word(imem_if.addr);
          wcnt = 0;
        end else begin
          imem_if.rvalid = 1'b0;
          wcnt++;
        end
      end else begin
        imem_if.rvalid = force_rv;
        imem_if.rdata  = 32'hDEAD_BEEF;
        wcnt = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_valid(input int max, input string nm);
    int n;
    n = 0;
    while (!instr_valid && n < max) begin
      @(negedge clk);
      n++;
    end
    chk(nm, {63'd0, instr_valid}, 64'd1);
  endtask

  task automatic do_retire(input logic [2:0] op, input logic [63:0] off, input logic [63:0] tgt,
                           input logic z, input logic [3:0] fl, input logic [3:0] cd, input logic h);
    branch_op = op; branch_offset = off; br_target = tgt;
    alu_zero = z; flags = fl; cond = cd; halt = h; retire = 1'b1;
    @(negedge clk);
    retire = 1'b0; halt = 1'b0; branch_op = 3'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] exp_pcs [4];
    int n, guard;
    exp_pcs[0] = 64'h0; exp_pcs[1] = 64'h4; exp_pcs[2] = 64'h8; exp_pcs[3] = 64'hC;

    @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_pc", pc, 64'h0);
    chk("rst_req", {63'd0, imem_if.req}, 64'd0);
    chk("rst_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_instr", {32'd0, instruction}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    reset = 1'b0;

    // sequential fetch
    for (int i = 0; i < 4; i++) begin
      wait_valid(10, "seq_valid");
      chk("seq_pc", pc, exp_pcs[i]);
      chk("seq_pc4", pc_plus4, exp_pcs[i] + 64'd4);
      chk("seq_instr", {32'd0, instruction}, {32'd0, 32'hE000_0000 | exp_pcs[i][31:0]});
      do_retire(BR_NONE, 64'd0, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    end

    // relative branches
    wait_valid(10, "b_valid");
    do_retire(BR_B, 64'h3C, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    wait_valid(10, "b_valid");
    chk("b_to_100", pc, 64'h100);
    do_retire(BR_B, -64'sd4, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    wait_valid(10, "b_valid");
    chk("b_back", imem_if.addr, 64'hF0);
    do_retire(BR_B, 64'd4, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    wait_valid(10, "bl_valid");
    chk("bl_link", pc_plus4, 64'h104);
    do_retire(BR_BL, 64'd3, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    wait_valid(10, "bl_valid");
    chk("bl_target", pc, 64'h10C);

    // conditional branches
    do_retire(BR_CBZ, 64'd2, 64'd0, 1'b1, 4'd0, 4'd0, 1'b0);
    wait_valid(10, "cbz_valid");
    chk("cbz_taken", pc, 64'h114);
    do_retire(BR_CBZ, 64'd2, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    wait_valid(10, "cbz_valid");
    chk("cbz_not", pc, 64'h118);
    do_retire(BR_COND, -64'sd2, 64'd0, 1'b0, 4'b1001, COND_GE, 1'b0);
    wait_valid(10, "ge_valid");
    chk("ge_taken", pc, 64'h110);
    do_retire(BR_COND, -64'sd2, 64'd0, 1'b0, 4'b1000, COND_GE, 1'b0);
    wait_valid(10, "ge_valid");
    chk("ge_not", pc, 64'h114);
    do_retire(BR_CBNZ, 64'd1, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    wait_valid(10, "cbnz_valid");
    chk("cbnz_taken", pc, 64'h118);
    do_retire(3'd7, 64'd5, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    wait_valid(10, "undef_valid");
    chk("undef_op", pc, 64'h11C);

    // slowest fetch that still completes
    mem_lat = TIMEOUT - 1;
    do_retire(BR_NONE, 64'd0, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    wait_valid(40, "slow_valid");
    chk("slow_pc", pc, 64'h120);
    chk("slow_fault", {63'd0, fault}, 64'd0);
    mem_lat = 0;

    // retire with halt
    do_retire(BR_NONE, 64'd0, 64'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    chk("halt_pc", pc, 64'h124);
    repeat (4) @(negedge clk);
    chk("halt_req", {63'd0, imem_if.req}, 64'd0);
    chk("halt_valid", {63'd0, instr_valid}, 64'd0);

    // misaligned register target
    do_reset();
    wait_valid(10, "reg_valid");
    do_retire(BR_REG, 64'd0, 64'h2002, 1'b0, 4'd0, 4'd0, 1'b0);
    chk("mis_fault", {63'd0, fault}, 64'd1);
    chk("mis_req", {63'd0, imem_if.req}, 64'd0);
    chk("mis_pc", pc, 64'h0);
    do_retire(BR_NONE, 64'd0, 64'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    repeat (4) @(negedge clk);
    chk("mis_sticky", {63'd0, fault}, 64'd1);
    chk("mis_pc_hold", pc, 64'h0);

    // imem timeout
    mem_lat = TIMEOUT;
    do_reset();
    chk("to_cleared", {63'd0, fault}, 64'd0);
    guard = 0;
    while (!imem_if.req && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    n = 0;
    while (!fault && n < 40) begin
      if (imem_if.req) n++;
      @(negedge clk);
    end
    chk("to_cycles", 64'(n), 64'd16);
    chk("to_fault", {63'd0, fault}, 64'd1);
    mem_lat = 3;

    // reset in the middle of a fetch, with a stray rvalid around the release
    do_reset();
    guard = 0;
    while (!imem_if.req && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    reset = 1'b1;
    force_rv = 1'b1;
    #1;
    chk("mid_req", {63'd0, imem_if.req}, 64'd0);
    chk("mid_valid", {63'd0, instr_valid}, 64'd0);
    chk("mid_pc", pc, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    force_rv = 1'b0;
    @(negedge clk);
    chk("late_rv_ignored", {32'd0, instruction}, 64'd0);
    wait_valid(20, "post_rst_valid");
    chk("post_rst_instr", {32'd0, instruction}, 64'hE000_0000);

    repeat (2) @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
